// File: rtl/sigma_delta_adc_ctrl.sv
// Capture sequencer between the sigma-delta ADC harness and a downstream consumer.
// Discards CIC settling strobes, then captures a burst or stream through a one-deep holding register.
module sigma_delta_adc_ctrl #(
   parameter int unsigned ADC_BITLEN     = 24,
   parameter int unsigned SETTLE_SAMPLES = 4,
   parameter int unsigned COUNT_W        = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic [COUNT_W-1:0]    burst_len_i,
   output logic                  adc_en_o,
   input  logic [ADC_BITLEN-1:0] adc_data_i,
   input  logic                  adc_valid_i,
   output logic [ADC_BITLEN-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  overrun_o,
   output logic [COUNT_W-1:0]    ovr_count_o
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SETTLE  = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   localparam int unsigned     SET_W       = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_SAMPLES - 1);

   logic [1:0]            state_q,      state_d;
   logic [SET_W-1:0]      settle_cnt_q, settle_cnt_d;
   logic [COUNT_W-1:0]    cap_cnt_q,    cap_cnt_d;
   logic [COUNT_W-1:0]    burst_len_q,  burst_len_d;
   logic [ADC_BITLEN-1:0] out_data_q,   out_data_d;
   logic                  out_valid_q,  out_valid_d;
   logic                  overrun_q,    overrun_d;
   logic [COUNT_W-1:0]    ovr_count_q,  ovr_count_d;
   logic                  done_q,       done_d;
   logic                  load;

   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      cap_cnt_d    = cap_cnt_q;
      burst_len_d  = burst_len_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      overrun_d    = overrun_q;
      ovr_count_d  = ovr_count_q;
      done_d       = 1'b0;
      load         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               burst_len_d  = burst_len_i;
               overrun_d    = 1'b0;
               ovr_count_d  = '0;
               settle_cnt_d = '0;
               cap_cnt_d    = '0;
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (stop_i) begin
               state_d = S_IDLE;
            end else if (adc_valid_i) begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  state_d = S_CAPTURE;
               end else begin
                  settle_cnt_d = settle_cnt_q + SET_W'(1);
               end
            end
         end
         S_CAPTURE: begin
            if (stop_i) begin
               state_d = S_DRAIN;
            end else if (adc_valid_i) begin
               // Register is free if empty or being emptied by this cycle's handshake.
               if (!out_valid_q || out_ready_i) begin
                  load       = 1'b1;
                  out_data_d = adc_data_i;
                  if (cap_cnt_q != '1) begin
                     cap_cnt_d = cap_cnt_q + COUNT_W'(1);
                  end
                  if ((burst_len_q != '0) && (cap_cnt_q == burst_len_q - COUNT_W'(1))) begin
                     state_d = S_DRAIN;
                  end
               end else begin
                  overrun_d = 1'b1;
                  if (ovr_count_q != '1) begin
                     ovr_count_d = ovr_count_q + COUNT_W'(1);
                  end
               end
            end
         end
         S_DRAIN: begin
            if (!out_valid_q || out_ready_i) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         settle_cnt_q <= '0;
         cap_cnt_q    <= '0;
         burst_len_q  <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         ovr_count_q  <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         cap_cnt_q    <= cap_cnt_d;
         burst_len_q  <= burst_len_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
         ovr_count_q  <= ovr_count_d;
         done_q       <= done_d;
      end
   end

   assign adc_en_o    = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign overrun_o   = overrun_q;
   assign ovr_count_o = ovr_count_q;

endmodule

// File: tb/tb_sigma_delta_adc_ctrl.sv
// Bench for sigma_delta_adc_ctrl: directed scenarios plus randomized captures,
// every cycle compared against a phase/count reference model and an accept scoreboard.
module tb_sigma_delta_adc_ctrl;

   localparam int unsigned W      = 24;
   localparam int unsigned SETTLE = 4;
   localparam int unsigned CW     = 16;

   logic          clk;
   logic          rst, start, stop, adc_valid, out_ready;
   logic [CW-1:0] burst_len;
   logic [W-1:0]  adc_data;
   logic          adc_en, out_valid, busy, done, overrun;
   logic [W-1:0]  out_data;
   logic [CW-1:0] ovr_count;

   sigma_delta_adc_ctrl #(
      .ADC_BITLEN     (W),
      .SETTLE_SAMPLES (SETTLE),
      .COUNT_W        (CW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .stop_i      (stop),
      .burst_len_i (burst_len),
      .adc_en_o    (adc_en),
      .adc_data_i  (adc_data),
      .adc_valid_i (adc_valid),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .busy_o      (busy),
      .done_o      (done),
      .overrun_o   (overrun),
      .ovr_count_o (ovr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {PH_IDLE, PH_SETTLE, PH_CAPTURE, PH_DRAIN} phase_t;

   phase_t        m_ph;
   int unsigned   m_settle, m_acc, m_len, m_ovc;
   bit            m_ov, m_ovr, m_done;
   logic [W-1:0]  m_data;
   logic [W-1:0]  sb[$];

   int            checks = 0;
   int            errors = 0;
   int            pops   = 0;
   int            dones  = 0;
   logic [W-1:0]  last_d;
   logic [W-1:0]  held;
   int unsigned   gap;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = PH_IDLE; m_settle = 0; m_acc = 0; m_len = 0; m_ovc = 0;
      m_ov = 0; m_ovr = 0; m_done = 0; m_data = '0;
      sb.delete();
   endtask

   // One clock of the reference behaviour, from the pre-edge view of state and inputs.
   task automatic model_step(input bit r, input bit st, input bit sp, input bit v,
                             input logic [W-1:0] d, input bit rdy);
      bit loaded;
      bit nd;
      if (r) begin
         model_reset();
         return;
      end
      loaded = 0;
      nd     = 0;
      case (m_ph)
         PH_IDLE: if (st) begin
            m_len = int'(burst_len); m_ovr = 0; m_ovc = 0; m_settle = 0; m_acc = 0;
            m_ph = PH_SETTLE;
         end
         PH_SETTLE: if (sp) m_ph = PH_IDLE;
            else if (v) begin
               m_settle++;
               if (m_settle == SETTLE) m_ph = PH_CAPTURE;
            end
         PH_CAPTURE: if (sp) m_ph = PH_DRAIN;
            else if (v) begin
               if (!m_ov || rdy) begin
                  loaded = 1; m_data = d; m_acc++; sb.push_back(d);
                  if (m_len != 0 && m_acc == m_len) m_ph = PH_DRAIN;
               end else begin
                  m_ovr = 1;
                  if (m_ovc < (2**CW - 1)) m_ovc++;
               end
            end
         PH_DRAIN: if (!m_ov || rdy) begin
            m_ph = PH_IDLE; nd = 1;
         end
         default: m_ph = PH_IDLE;
      endcase
      if (loaded) m_ov = 1;
      else if (m_ov && rdy) m_ov = 0;
      m_done = nd;
   endtask

   task automatic step(input bit r, input bit st, input bit sp, input bit v, input bit rdy);
      logic [W-1:0] d;
      logic [W-1:0] e;
      @(negedge clk);
      d = W'($urandom);
      rst = r; start = st; stop = sp; adc_valid = v; adc_data = d; out_ready = rdy;
      if (v) last_d = d;
      if (!r && m_ov && rdy) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("accept_data", out_data, e);
            pops++;
         end
      end
      if (!r && m_ov && rdy && !(m_ph == PH_CAPTURE && v && !sp)) sb.delete();
      model_step(r, st, sp, v, d, rdy);
      @(posedge clk);
      #1;
      chk("adc_en",    adc_en,    (m_ph == PH_SETTLE || m_ph == PH_CAPTURE));
      chk("busy",      busy,      (m_ph != PH_IDLE));
      chk("done",      done,      m_done);
      chk("out_valid", out_valid, m_ov);
      chk("out_data",  out_data,  m_data);
      chk("overrun",   overrun,   m_ovr);
      chk("ovr_count", ovr_count, m_ovc);
      if (done) dones++;
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) step(0, 0, 0, 0, rdy);
   endtask

   task automatic strobe(input int g, input bit rdy);
      idle(g - 1, rdy);
      step(0, 0, 0, 1, rdy);
   endtask

   task automatic begin_capture(input int unsigned len);
      burst_len = CW'(len);
      step(0, 1, 0, 0, 1);
      repeat (SETTLE) strobe(8, 1);
   endtask

   task automatic drain(input int maxc);
      int k;
      k = 0;
      while (m_ph != PH_IDLE && k < maxc) begin
         step(0, 0, 0, 0, 1);
         k++;
      end
      chk("drain_idle", busy, 1'b0);
   endtask

   initial begin
      rst = 1; start = 0; stop = 0; adc_valid = 0; out_ready = 0;
      burst_len = '0; adc_data = '0; last_d = '0; held = '0; gap = 1;
      model_reset();

      // Reset state
      repeat (3) step(1, 0, 0, 0, 0);
      idle(2, 0);
      chk("rst_ovr_count", ovr_count, 0);

      // Burst: 4 settle strobes discarded, 8 captured, strobes every 256 clocks
      pops = 0; dones = 0;
      burst_len = 16'd8;
      step(0, 1, 0, 0, 1);
      repeat (12) strobe(256, 1);
      idle(3, 1);
      chk("burst_pops",  pops,   8);
      chk("burst_dones", dones,  1);
      chk("burst_adcen", adc_en, 1'b0);

      // Stall: three strobes with consumer stalled
      pops = 0; dones = 0;
      begin_capture(4);
      strobe(5, 0);
      held = last_d;
      strobe(5, 0);
      strobe(5, 0);
      chk("stall_data",    out_data,  held);
      chk("stall_overrun", overrun,   1'b1);
      chk("stall_ovrcnt",  ovr_count, 2);
      step(0, 0, 0, 0, 1);
      repeat (3) strobe(5, 1);
      idle(3, 1);
      chk("stall_pops",   pops,      4);
      chk("stall_hold",   ovr_count, 2);
      chk("stall_dones",  dones,     1);

      // Simultaneous load and accept
      pops = 0;
      begin_capture(3);
      strobe(4, 1);
      step(0, 0, 0, 1, 1);
      chk("simul_valid",   out_valid, 1'b1);
      chk("simul_overrun", overrun,   1'b0);
      strobe(4, 1);
      drain(20);
      chk("simul_pops", pops, 3);

      // Continuous, then stop with a held sample and a stalled consumer
      pops = 0; dones = 0;
      begin_capture(0);
      repeat (99) strobe(4, 1);
      idle(3, 1);
      step(0, 0, 0, 1, 0);
      held = last_d;
      step(0, 0, 1, 1, 0);
      repeat (5) step(0, 0, 0, 1, 0);
      chk("cont_data",  out_data,  held);
      chk("cont_valid", out_valid, 1'b1);
      chk("cont_busy",  busy,      1'b1);
      chk("cont_nodone", dones,    0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("cont_dones", dones, 1);
      chk("cont_pops",  pops,  100);

      // Abort in SETTLE
      dones = 0;
      burst_len = 16'd5;
      step(0, 1, 0, 0, 1);
      strobe(8, 1);
      strobe(8, 1);
      step(0, 0, 1, 0, 1);
      chk("abort_busy",  busy,      1'b0);
      chk("abort_valid", out_valid, 1'b0);
      idle(2, 1);
      chk("abort_dones", dones, 0);

      // Start while busy (in SETTLE and in DRAIN) is ignored
      pops = 0;
      burst_len = 16'd3;
      step(0, 1, 0, 0, 1);
      strobe(8, 1);
      strobe(8, 1);
      burst_len = 16'd9;
      step(0, 1, 0, 0, 1);
      strobe(8, 1);
      strobe(8, 1);
      strobe(4, 1);
      strobe(4, 1);
      idle(3, 1);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      drain(20);
      chk("busy_start_pops", pops, 3);

      // Reset mid-capture with a held sample, then a clean burst
      begin_capture(6);
      strobe(4, 0);
      step(1, 0, 0, 0, 0);
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_data",  out_data,  0);
      pops = 0;
      begin_capture(2);
      strobe(4, 1);
      strobe(4, 1);
      drain(20);
      chk("midrst_pops", pops, 2);

      // Randomized captures with random gaps, backpressure and stops
      for (int run = 0; run < 10; run++) begin
         burst_len = CW'($urandom_range(0, 6));
         step(0, 1, 0, 0, 1);
         for (int n = 0; n < 40 && m_ph != PH_IDLE && m_ph != PH_DRAIN; n++) begin
            gap = $urandom_range(1, 5);
            repeat (gap - 1) step(0, 0, 0, 0, ($urandom % 4) != 0);
            step(0, 0, (($urandom % 24) == 0) || (n == 39), 1, ($urandom % 4) != 0);
         end
         drain(200);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
